// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: reads 32-bit program-memory words and re-packs the mixed
// RVC/32-bit stream into one instruction per handshake. Optional macro: FETCH_ALIGNER_ILLEGAL_DET_EN.
module fetch_aligner #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_c
`ifdef FETCH_ALIGNER_ILLEGAL_DET_EN
  , output logic      instr_illegal
`endif
);

  localparam logic [ADDR_W-1:0] RST_PC    = RESET_PC[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] HALF_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

  logic [3:0][15:0]  r_q;
  logic [2:0]        r_count;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [ADDR_W-1:0] r_head_pc;
  logic              r_skip_lo;

  logic              w_head_is_c;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_pop_n;
  logic [2:0]        w_push_n;
  logic [2:0]        w_rem;
  logic [15:0]       w_pd0;
  logic [15:0]       w_pd1;
  logic [3:0][15:0]  w_q_nxt;
  logic              w_unused;

  assign w_unused = ^redirect_pc[31:ADDR_W];

  // Head decode: the low two bits of the oldest halfword select RVC vs 32-bit.
  assign w_head_is_c = (r_q[0][1:0] != 2'b11);
  assign instr_valid = w_head_is_c ? (r_count >= 3'd1) : (r_count >= 3'd2);
  assign instr_is_c  = instr_valid && w_head_is_c;
  assign instr       = !instr_valid ? 32'h0 :
                       w_head_is_c  ? {16'h0, r_q[0]} : {r_q[1], r_q[0]};
  assign instr_pc    = 32'(r_head_pc);
  assign mem_addr    = 32'(r_fetch_addr);

`ifdef FETCH_ALIGNER_ILLEGAL_DET_EN
  assign instr_illegal = instr_valid &&
                         (w_head_is_c ? (r_q[0] == 16'h0000) : ({r_q[1], r_q[0]} == 32'hFFFF_FFFF));
`endif

  assign w_pop    = instr_valid && instr_ready;
  assign w_pop_n  = !w_pop ? 3'd0 : (w_head_is_c ? 3'd1 : 3'd2);
  assign w_push   = (r_count <= 3'd2) && !redirect_valid;
  assign w_push_n = !w_push ? 3'd0 : (r_skip_lo ? 3'd1 : 3'd2);
  assign w_pd0    = r_skip_lo ? mem_rdata[31:16] : mem_rdata[15:0];
  assign w_pd1    = mem_rdata[31:16];
  assign w_rem    = r_count - w_pop_n;

  // Shift out popped entries, then append pushed halves right after the survivors.
  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] src;
      src = 3'(i) + w_pop_n;
      if (3'(i) < w_rem)
        w_q_nxt[i] = r_q[src[1:0]];
      else if ((3'(i) == w_rem) && (w_push_n != 3'd0))
        w_q_nxt[i] = w_pd0;
      else if ((3'(i) == (w_rem + 3'd1)) && (w_push_n == 3'd2))
        w_q_nxt[i] = w_pd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q          <= '0;
      r_count      <= 3'd0;
      r_fetch_addr <= RST_PC & WORD_MASK;
      r_head_pc    <= RST_PC & HALF_MASK;
      r_skip_lo    <= RESET_PC[1];
    end else if (redirect_valid) begin
      r_count      <= 3'd0;
      r_fetch_addr <= redirect_pc[ADDR_W-1:0] & WORD_MASK;
      r_head_pc    <= redirect_pc[ADDR_W-1:0] & HALF_MASK;
      r_skip_lo    <= redirect_pc[1];
    end else begin
      r_q     <= w_q_nxt;
      r_count <= w_rem + w_push_n;
      if (w_push) begin
        r_fetch_addr <= r_fetch_addr + ADDR_W'(4);
        r_skip_lo    <= 1'b0;
      end
      if (w_pop)
        r_head_pc <= r_head_pc + (w_head_is_c ? ADDR_W'(2) : ADDR_W'(4));
    end
  end

endmodule
